// File: rtl/oai_cell_pkg.sv
// oai_cell_pkg: gate-mode enum and the single-lane OAI21/AOI21 function shared by the pipe array
package oai_cell_pkg;

    typedef enum logic {
        MODE_OAI21 = 1'b0,
        MODE_AOI21 = 1'b1
    } mode_e;

    function automatic logic lane_fn(input logic a, input logic b, input logic c, input mode_e m);
        return (m == MODE_AOI21) ? ~((a & b) | c) : ~((a | b) & c);
    endfunction

endpackage

// File: rtl/oai21_pipe_stage.sv
// oai21_pipe_stage: one valid/data register slice of an elastic pipeline
// Ports: clk, rst (async active-high); in_valid/in_data from upstream, ready back to it;
//        valid/data to downstream, out_ready from it.
module oai21_pipe_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Ready when empty or when the current item leaves this cycle.
    assign ready = ~valid_q | out_ready;
    assign valid = valid_q;
    assign data  = data_q;

    always_comb begin
        valid_d = ready ? in_valid : valid_q;
        data_d  = (ready && in_valid) ? in_data : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/oai21_pipe_array.sv
// oai21_pipe_array: WIDTH-lane OAI21/AOI21 gate array behind a STAGES-deep valid/ready pipeline
// Ports: CLK, R (async active-high); A/B/C lane inputs, MODE (0 OAI21, 1 AOI21), VI/RI input
//        handshake; Y/VO/RO output handshake; TCNT/TCLR toggle counter (OAI_TOGGLE_CNT_EN only).
module oai21_pipe_array
    import oai_cell_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             R,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             MODE,
    input  logic             VI,
    output logic             RI,
    output logic [WIDTH-1:0] Y,
    output logic             VO,
`ifdef OAI_TOGGLE_CNT_EN
    output logic [CNT_W-1:0] TCNT,
    input  logic             TCLR,
`endif
    input  logic             RO
);

    logic [WIDTH-1:0] gate;
    logic [STAGES:0]  v;
    logic [WIDTH-1:0] d   [STAGES+1];
    logic             rdy [STAGES+1];

    // The gate is evaluated at accept time, so MODE is captured with its operands.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign gate[i] = lane_fn(A[i], B[i], C[i], mode_e'(MODE));
    end

    assign v[0]        = VI;
    assign d[0]        = gate;
    assign rdy[STAGES] = RO;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        oai21_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (CLK),
            .rst      (R),
            .in_valid (v[k]),
            .in_data  (d[k]),
            .out_ready(rdy[k+1]),
            .valid    (v[k+1]),
            .data     (d[k+1]),
            .ready    (rdy[k])
        );
    end

    assign RI = rdy[0];
    assign VO = v[STAGES];
    assign Y  = d[STAGES];

`ifdef OAI_TOGGLE_CNT_EN
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [6:0]       pc;
    logic [CNT_W+6:0] sum;
    logic             xfer;

    assign xfer = VO & RO;
    assign TCNT = tcnt_q;

    // Wide sum so any carry above CNT_W bits signals saturation.
    always_comb begin
        pc = '0;
        for (int j = 0; j < WIDTH; j++) pc = pc + 7'(Y[j] ^ prev_q[j]);
        sum    = {7'd0, tcnt_q} + (CNT_W+7)'(pc);
        tcnt_d = TCLR ? '0 : xfer ? ((|sum[CNT_W+6:CNT_W]) ? '1 : sum[CNT_W-1:0]) : tcnt_q;
        prev_d = xfer ? Y : prev_q;
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            tcnt_q <= '0;
            prev_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            prev_q <= prev_d;
        end
    end
`endif

endmodule

// File: doc/oai21_pipe_array.md
OAI21_PIPE_ARRAY -- requirements
Module: oai21_pipe_array

Interface
REQ-001 Parameter WIDTH, default 4, number of independent gate lanes (1..32).
REQ-002 Parameter STAGES, default 2, pipeline depth in register stages (1..4).
REQ-003 Parameter CNT_W, default 16, width of the toggle counter.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 R  input  1  reset; asynchronous, active-high.
REQ-006 A  input  WIDTH  lane input A.
REQ-007 B  input  WIDTH  lane input B.
REQ-008 C  input  WIDTH  lane input C.
REQ-009 MODE  input  1  gate select: 0 = OAI21, 1 = AOI21.
REQ-010 VI  input  1  input valid.
REQ-011 RI  output  1  input ready.
REQ-012 Y  output  WIDTH  registered result of the last stage.
REQ-013 VO  output  1  output valid.
REQ-014 RO  input  1  output ready from the downstream consumer.
REQ-015 TCNT  output  CNT_W  toggle count; present only when OAI_TOGGLE_CNT_EN is defined.
REQ-016 TCLR  input  1  synchronous toggle-count clear; present only when OAI_TOGGLE_CNT_EN is defined.

Function
REQ-017 When MODE=0, each lane i SHALL compute Y[i] = ~((A[i]|B[i])&C[i]).
REQ-018 When MODE=1, each lane i SHALL compute Y[i] = ~((A[i]&B[i])|C[i]).
REQ-019 MODE SHALL be sampled together with A/B/C on the accept cycle and travel with the data.
REQ-020 An input transfer SHALL occur on a cycle with VI=1 and RI=1.
REQ-021 An output transfer SHALL occur on a cycle with VO=1 and RO=1.
REQ-022 Each stage holds one valid bit and a WIDTH-bit data register; stage k SHALL advance when stage k+1 is empty or advancing.
REQ-023 The last stage SHALL advance when it is empty or RO=1.
REQ-024 RI SHALL equal (stage 0 empty) OR (stage 0 advancing), combinationally; there is no combinational path from VI to RI.
REQ-025 Latency SHALL be exactly STAGES cycles from input transfer to VO=1 when RO is held at 1.
REQ-026 With RO=1 held, throughput SHALL be one transfer per cycle with no bubbles.
REQ-027 While VO=1 and RO=0, Y and VO SHALL hold stable.
REQ-028 With RO=0 held, the pipeline SHALL accept exactly STAGES items, then drive RI=0.
REQ-029 On a cycle where the pipeline is full and RO=1, RI SHALL be 1 and the input and output transfers SHALL both occur in that same cycle.
REQ-030 Data SHALL never be dropped or duplicated; output order SHALL equal input order.
REQ-031 No state machine is used beyond the per-stage valid bits: each stage is either EMPTY or FULL, and goes EMPTY->FULL on load and FULL->EMPTY on drain without reload.

Reset
REQ-032 While R=1, all valid bits and Y SHALL clear to 0 immediately, asynchronously; TCNT SHALL also clear to 0.
REQ-033 An assertion of R mid-stream SHALL discard all in-flight items.
REQ-034 RI SHALL be 1 on the first cycle after R deasserts.

Configuration
REQ-035 The macro OAI_TOGGLE_CNT_EN compiles in the toggle counter; when it is absent, TCNT, TCLR and the counter logic SHALL not exist.
REQ-036 When the macro is defined, on each output transfer TCNT SHALL add popcount(Y XOR previous transferred Y); the previous value is 0 after reset.
REQ-037 TCNT SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-038 TCLR=1 SHALL set TCNT to 0 and SHALL take priority over a simultaneous increment.

Structure
REQ-039 A shared package oai_cell_pkg SHALL hold the mode enum (MODE_OAI21=0, MODE_AOI21=1) and the function computing one lane result.
REQ-040 One sub-module, oai21_pipe_stage (a single valid/data register slice), SHALL be instantiated STAGES times.

Verification
REQ-041 WIDTH=4, STAGES=2, RO=1; A=4'b0011, B=4'b0101, C=4'b1111, MODE=0 -> Y=4'b1000 with VO=1 exactly 2 cycles after accept.
REQ-042 Same inputs with MODE=1, C=4'b0000 -> Y=4'b1110.
REQ-043 RO=0, VI=1 for 4 cycles -> RI=0 after 2 accepts; raise RO -> the 2 items drain in order, then accept resumes with no loss.
REQ-044 Assert R while 2 items are in flight -> VO=0 and Y=0 immediately; RI=1 on the first cycle after release.
REQ-045 With OAI_TOGGLE_CNT_EN and CNT_W=4, stream alternating Y=4'hF/4'h0 -> TCNT counts 4, 8, 12, 15, 15 (saturates).
REQ-046 With OAI_TOGGLE_CNT_EN, assert TCLR on the same cycle as an output transfer -> TCNT=0.
